// File: rtl/result_dest_pipe_if.sv
// Operand-forwarding producer bundle: ID/EX inputs, pipeline control and the
// published EX/MEM and MEM/WB destination state.
interface result_dest_pipe_if #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
);
    // No valid/ready pair here: the pipeline advances on every edge unless
    // hold=1, and the consumer must treat load_use_stall as a same-cycle
    // request to freeze PC/IF-ID and bubble ID/EX.
    logic              hold;
    logic              flush;
    logic [REG_AW-1:0] idex_rd;
    logic              idex_regwrite;
    logic              idex_memread;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;

    logic [REG_AW-1:0] EXMEM_RegisterRd;
    logic              EXMEM_RegWrite;
    logic [DATA_W-1:0] EXMEM_result;
    logic [REG_AW-1:0] MEMWB_RegisterRd;
    logic              MEMWB_RegWrite;
    logic [DATA_W-1:0] MEMWB_data;
    logic              load_use_stall;
    logic              debug_state;

    modport master (
        output hold, flush, idex_rd, idex_regwrite, idex_memread,
               ex_result, mem_rdata, id_rn, id_rm,
        input  EXMEM_RegisterRd, EXMEM_RegWrite, EXMEM_result,
               MEMWB_RegisterRd, MEMWB_RegWrite, MEMWB_data,
               load_use_stall, debug_state
    );

    modport slave (
        input  hold, flush, idex_rd, idex_regwrite, idex_memread,
               ex_result, mem_rdata, id_rn, id_rm,
        output EXMEM_RegisterRd, EXMEM_RegWrite, EXMEM_result,
               MEMWB_RegisterRd, MEMWB_RegWrite, MEMWB_data,
               load_use_stall, debug_state
    );
endinterface

// File: rtl/result_dest_pipe.sv
// EX/MEM and MEM/WB destination registers with load-use stall detection.
// Optional STALL_STATS_EN adds a saturating 32-bit stall_count output.
module result_dest_pipe #(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    result_dest_pipe_if.slave   bus
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]         stall_count
`endif
);

    typedef enum logic {NORMAL = 1'b0, BUBBLE = 1'b1} state_t;

    state_t            state;
    state_t            state_next;
    logic              hazard;
    logic              stall;
    logic              cap_regwrite;
    logic              cap_memread;
    logic              exmem_memread;
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_regwrite;
    logic [DATA_W-1:0] exmem_result;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_regwrite;
    logic [DATA_W-1:0] memwb_data;

    assign hazard = bus.idex_memread && bus.idex_regwrite
                 && (bus.idex_rd != REG_AW'(ZERO_REG))
                 && ((bus.idex_rd == bus.id_rn) || (bus.idex_rd == bus.id_rm));

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            NORMAL: begin
                stall = hazard && !bus.hold && !bus.flush;
                if (stall) state_next = BUBBLE;
            end
            BUBBLE: begin
                if (!bus.hold) state_next = NORMAL;
            end
            default: state_next = NORMAL;
        endcase
    end

    // While in BUBBLE the ID/EX slot holds the inserted bubble, so its
    // write/load qualifiers must not be published.
    assign cap_regwrite = bus.idex_regwrite && (state == NORMAL)
                       && (bus.idex_rd != REG_AW'(ZERO_REG));
    assign cap_memread  = bus.idex_memread && (state == NORMAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= NORMAL;
            exmem_rd       <= '0;
            exmem_regwrite <= 1'b0;
            exmem_memread  <= 1'b0;
            exmem_result   <= '0;
            memwb_rd       <= '0;
            memwb_regwrite <= 1'b0;
            memwb_data     <= '0;
        end else if (!bus.hold) begin
            state          <= state_next;
            memwb_rd       <= exmem_rd;
            memwb_regwrite <= exmem_regwrite;
            memwb_data     <= exmem_memread ? bus.mem_rdata : exmem_result;
            if (bus.flush) begin
                exmem_rd       <= '0;
                exmem_regwrite <= 1'b0;
                exmem_memread  <= 1'b0;
                exmem_result   <= '0;
            end else begin
                exmem_rd       <= bus.idex_rd;
                exmem_regwrite <= cap_regwrite;
                exmem_memread  <= cap_memread;
                exmem_result   <= bus.ex_result;
            end
        end
    end

`ifdef STALL_STATS_EN
    // stall is already zero under hold, so hold freezes the counter too.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

    assign bus.EXMEM_RegisterRd = exmem_rd;
    assign bus.EXMEM_RegWrite   = exmem_regwrite;
    assign bus.EXMEM_result     = exmem_result;
    assign bus.MEMWB_RegisterRd = memwb_rd;
    assign bus.MEMWB_RegWrite   = memwb_regwrite;
    assign bus.MEMWB_data       = memwb_data;
    assign bus.load_use_stall   = stall;
    assign bus.debug_state      = state;

endmodule
